td4_prog_loader: RTL and testbench



---
 rtl/td4_prog_loader.sv | 167 ++++++++++++++++
 tb/tb_td4_prog_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// rtl/td4_prog_loader.sv - TD4 16x8 program memory with byte-serial host loader and run gating.
// Optional checksum byte/CHECK state enabled by defining TD4_LOAD_CHECKSUM_EN.
module td4_prog_loader #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_mode,
    input  logic             wr_strobe,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       pc,
    output logic [WIDTH-1:0] instr,
    output logic [3:0]       load_addr,
    output logic             core_run,
    output logic             load_done,
    output logic             load_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             lm_s1_q, lm_s2_q;
    logic             st_s1_q, st_s2_q, st_s3_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [3:0]       load_addr_q, load_addr_d;
    logic             load_done_q, load_done_d;
    logic             wr_pulse;
    logic             err_now;
`ifdef TD4_LOAD_CHECKSUM_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             load_err_q, load_err_d;
    logic             lock_q, lock_d;
`endif

    assign wr_pulse = st_s2_q & ~st_s3_q;
`ifdef TD4_LOAD_CHECKSUM_EN
    assign err_now = load_err_q;
`else
    assign err_now = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        instr_d     = instr_q;
        load_addr_d = load_addr_q;
        load_done_d = load_done_q;
`ifdef TD4_LOAD_CHECKSUM_EN
        acc_d       = acc_q;
        load_err_d  = load_err_q;
        lock_d      = lock_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (lm_s2_q) begin
                    state_d = S_LOAD;
                end else if (!err_now) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (!lm_s2_q) begin
                    state_d = S_IDLE;
`ifdef TD4_LOAD_CHECKSUM_EN
                end else if (wr_pulse && !lock_q) begin
`else
                end else if (wr_pulse) begin
`endif
                    mem_d[load_addr_q] = wr_data;
                    load_addr_d        = load_addr_q + 4'd1;
                    load_done_d        = 1'b0;
`ifdef TD4_LOAD_CHECKSUM_EN
                    acc_d = acc_q + wr_data;
                    if (load_addr_q == 4'd15) begin
                        state_d = S_CHECK;
                    end
`else
                    if (load_addr_q == 4'd15) begin
                        load_done_d = 1'b1;
                    end
`endif
                end
            end
`ifdef TD4_LOAD_CHECKSUM_EN
            S_CHECK: begin
                if (!lm_s2_q) begin
                    state_d    = S_IDLE;
                    load_err_d = 1'b1;
                end else if (wr_pulse) begin
                    if (WIDTH'(acc_q + wr_data) == '0) begin
                        load_done_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    lock_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
`endif
            S_RUN: begin
                instr_d = mem_q[pc];
                if (lm_s2_q) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every entry into LOAD (from IDLE or RUN) starts a fresh program.
        if (state_q != S_LOAD && state_q != S_CHECK && state_d == S_LOAD) begin
            load_addr_d = 4'd0;
            load_done_d = 1'b0;
`ifdef TD4_LOAD_CHECKSUM_EN
            acc_d       = '0;
            load_err_d  = 1'b0;
            lock_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lm_s1_q     <= 1'b0;
            lm_s2_q     <= 1'b0;
            st_s1_q     <= 1'b0;
            st_s2_q     <= 1'b0;
            st_s3_q     <= 1'b0;
            mem_q       <= '{default: '0};
            instr_q     <= '0;
            load_addr_q <= 4'd0;
            load_done_q <= 1'b0;
`ifdef TD4_LOAD_CHECKSUM_EN
            acc_q       <= '0;
            load_err_q  <= 1'b0;
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lm_s1_q     <= load_mode;
            lm_s2_q     <= lm_s1_q;
            st_s1_q     <= wr_strobe;
            st_s2_q     <= st_s1_q;
            st_s3_q     <= st_s2_q;
            mem_q       <= mem_d;
            instr_q     <= instr_d;
            load_addr_q <= load_addr_d;
            load_done_q <= load_done_d;
`ifdef TD4_LOAD_CHECKSUM_EN
            acc_q       <= acc_d;
            load_err_q  <= load_err_d;
            lock_q      <= lock_d;
`endif
        end
    end

    assign instr     = instr_q;
    assign load_addr = load_addr_q;
    assign core_run  = (state_q == S_RUN);
    assign load_done = load_done_q;
    assign load_err  = err_now;
endmodule

// File: tb/tb_td4_prog_loader.sv
// tb/tb_td4_prog_loader.sv - directed self-checking bench for td4_prog_loader.
module tb_td4_prog_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_mode = 1'b0;
    logic       wr_strobe = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] pc = 4'd0;
    logic [7:0] instr;
    logic [3:0] load_addr;
    logic       core_run;
    logic       load_done;
    logic       load_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] model [16];

    always #5 clk = ~clk;

    td4_prog_loader dut (
        .clk(clk), .rst(rst), .load_mode(load_mode), .wr_strobe(wr_strobe),
        .wr_data(wr_data), .pc(pc), .instr(instr), .load_addr(load_addr),
        .core_run(core_run), .load_done(load_done), .load_err(load_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data held 1 cycle before and 4 cycles after the strobe edge, then scrambled.
    task automatic send_byte(input logic [7:0] b);
        wr_data = b;
        tick(1);
        wr_strobe = 1'b1;
        tick(4);
        wr_data = 8'($urandom);
        tick(1);
        wr_strobe = 1'b0;
        tick(3);
    endtask

    task automatic enter_load();
        load_mode = 1'b1;
        tick(4);
    endtask

    task automatic enter_run();
        load_mode = 1'b0;
        tick(4);
    endtask

    task automatic sweep(input string tag);
        for (int p = 0; p < 16; p++) begin
            pc = 4'(p);
            tick(1);
            check($sformatf("%s_pc%0d", tag, p), instr, model[p]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, instr, 8'h00);
        check({tag, "_addr"}, load_addr, 4'd0);
        check({tag, "_run"}, core_run, 1'b0);
        check({tag, "_done"}, load_done, 1'b0);
        check({tag, "_err"}, load_err, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        tick(2);
        check_reset_outputs("rst0");
        rst = 1'b0;
        tick(3);
        check("run_after_reset", core_run, 1'b1);
        sweep("blank");

        // load_mode during RUN: core_run falls exactly 3 cycles later
        load_mode = 1'b1;
        tick(2);
        check("run_at_2", core_run, 1'b1);
        tick(1);
        check("run_at_3", core_run, 1'b0);
        tick(1);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h30 + 8'(i));
            model[i] = 8'h30 + 8'(i);
            if (i == 6) check("addr_after_7", load_addr, 4'd7);
        end
`ifdef TD4_LOAD_CHECKSUM_EN
        check("done_before_sum", load_done, 1'b0);
        send_byte(8'h88);
`endif
        check("full_done", load_done, 1'b1);
        check("full_addr_wrap", load_addr, 4'd0);
        check("full_err", load_err, 1'b0);
        enter_run();
        check("full_run", core_run, 1'b1);
        check("full_done_run", load_done, 1'b1);
        sweep("full");

        // strobes in RUN must not write
        send_byte(8'hEE);
        check("run_ignore_addr", load_addr, 4'd0);
        sweep("run_ignore");

        // partial load: 5 bytes then abort
        enter_load();
        check("partial_run_off", core_run, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hA0 + 8'(i));
            model[i] = 8'hA0 + 8'(i);
        end
        enter_run();
        check("partial_done", load_done, 1'b0);
        check("partial_addr", load_addr, 4'd5);
        check("partial_run", core_run, 1'b1);
        sweep("partial");

`ifdef TD4_LOAD_CHECKSUM_EN
        enter_load();
        for (int i = 0; i < 16; i++) send_byte(8'h01);
        send_byte(8'hF0);
        check("csum_ok_done", load_done, 1'b1);
        check("csum_ok_err", load_err, 1'b0);
        enter_run();
        check("csum_ok_run", core_run, 1'b1);
        enter_load();
        for (int i = 0; i < 16; i++) send_byte(8'h01);
        send_byte(8'hF1);
        check("csum_bad_err", load_err, 1'b1);
        check("csum_bad_done", load_done, 1'b0);
        enter_run();
        tick(4);
        check("csum_bad_blocked", core_run, 1'b0);
        for (int i = 0; i < 16; i++) model[i] = 8'h01;
`endif

        // reset after the 7th byte of a load
        enter_load();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        rst = 1'b1;
        load_mode = 1'b0;
        tick(1);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        tick(2);
        check("rst_mid_run", core_run, 1'b1);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        sweep("rst_mem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
